i2c_xfer_arbiter: RTL and testbench

//  Shares one two_wire_i2c master among NREQ requesters. Each requester asks for a
//  2-byte write: address byte {addr,1'b0}, then one data byte. Round-robin grant;

---
 rtl/i2c_xfer_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_xfer_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter that lets NREQ clients share one two-wire master for
// 2-byte writes (address byte, then data byte), with a per-byte watchdog.
module i2c_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              m_start,
  output logic [7:0]        m_data,
  input  logic              m_busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_A, WAIT_HI, WAIT_LO, SEND_D, FINISH, ABORT
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } xfer_t;

  state_t          state, state_nxt;
  xfer_t           xf, xf_nxt;
  logic [IW-1:0]   idx, idx_nxt, idx_p1;
  logic [IW-1:0]   rr, rr_nxt;
  logic            phase, phase_nxt;   // 0: address byte in flight, 1: data byte
  logic [TW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic            tmo;
  logic [NREQ-1:0] gnt_nxt, done_nxt, err_nxt, idx_oh;
  logic            m_start_nxt;
  logic [7:0]      m_data_nxt;
  logic            pick_vld;
  logic [IW-1:0]   pick;

  // First asserted request at or after the rr pointer, wrapping.
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = IW'(j);
      end
    end
  end

  // Watchdog saturates at TIMEOUT so it can never wrap back to a small value.
  assign cnt_inc = (cnt == TW'(TIMEOUT)) ? cnt : cnt + 1'b1;
  assign tmo     = (cnt_inc == TW'(TIMEOUT));
  assign idx_p1  = (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
  assign idx_oh  = NREQ'(1) << idx;

  always_comb begin
    state_nxt   = state;
    xf_nxt      = xf;
    idx_nxt     = idx;
    rr_nxt      = rr;
    phase_nxt   = phase;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    err_nxt     = '0;
    m_start_nxt = 1'b0;
    m_data_nxt  = m_data;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          idx_nxt     = pick;
          xf_nxt.addr = req_addr[int'(pick)*7 +: 7];
          xf_nxt.data = req_data[int'(pick)*8 +: 8];
          gnt_nxt     = NREQ'(1) << pick;
          state_nxt   = SEND_A;
        end
      end
      SEND_A: begin
        m_start_nxt = 1'b1;
        m_data_nxt  = {xf.addr, 1'b0};
        phase_nxt   = 1'b0;
        cnt_nxt     = '0;
        state_nxt   = WAIT_HI;
      end
      SEND_D: begin
        m_start_nxt = 1'b1;
        m_data_nxt  = xf.data;
        phase_nxt   = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_HI;
      end
      WAIT_HI: begin
        cnt_nxt = cnt_inc;
        if (m_busy) begin
          state_nxt = WAIT_LO;
        end else if (tmo) begin
          state_nxt  = ABORT;
          err_nxt    = idx_oh;
          m_data_nxt = '0;
        end
      end
      WAIT_LO: begin
        cnt_nxt = cnt_inc;
        if (!m_busy) begin
          if (phase) begin
            state_nxt = FINISH;
            done_nxt  = idx_oh;
          end else begin
            state_nxt = SEND_D;
          end
        end else if (tmo) begin
          state_nxt  = ABORT;
          err_nxt    = idx_oh;
          m_data_nxt = '0;
        end
      end
      FINISH, ABORT: begin
        gnt_nxt   = '0;
        rr_nxt    = idx_p1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      xf      <= '0;
      idx     <= '0;
      rr      <= '0;
      phase   <= 1'b0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      m_start <= 1'b0;
      m_data  <= 8'h00;
    end else begin
      state   <= state_nxt;
      xf      <= xf_nxt;
      idx     <= idx_nxt;
      rr      <= rr_nxt;
      phase   <= phase_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      m_start <= m_start_nxt;
      m_data  <= m_data_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Directed bench for i2c_xfer_arbiter: transaction-level model checked every
// cycle plus literal latency/order expectations for each scenario.
module tb_i2c_xfer_arbiter;
  localparam int NREQ = 4, TIMEOUT = 20, TW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, gnt, done, err;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ*8-1:0] req_data;
  logic              m_start, m_busy;
  logic [7:0]        m_data;
  logic              stuck = 1'b0;
  int                checks = 0, errors = 0;

  always #5 clk = ~clk;

  i2c_xfer_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_data(m_data),
    .m_busy(m_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rq(input int i, input logic [6:0] a, input logic [7:0] d);
    req_addr[i*7 +: 7] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic wait_pulse(input string nm, output logic [NREQ-1:0] d,
                            output logic [NREQ-1:0] e, output int cyc);
    bit hit = 1'b0;
    d = '0; e = '0; cyc = 0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      tick();
      if (done != 0 || err != 0) begin
        d = done; e = err; cyc = c; hit = 1'b1;
      end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: no done/err within 200 cycles", nm);
    end
  endtask

  task automatic wait_gnt(input string nm);
    bit hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      tick();
      if (gnt != 0) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: no grant within 50 cycles", nm);
    end
  endtask

  // Master stand-in: busy for 3 cycles after each start, or never when stuck.
  initial begin
    int bcnt;
    bcnt = 0; m_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) bcnt = 0;
      else if (m_start && !stuck) bcnt = 3;
      m_busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
    end
  end

  // Transaction-level model.
  function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  int              m_rr = 0, m_idx = 0, m_bytes = 0;
  bit              m_act = 1'b0, gnt_clr_due = 1'b0;
  logic [6:0]      m_addr;
  logic [7:0]      m_dat, last_byte;
  logic [NREQ-1:0] prev_req = '0, prev_gnt = '0;
  logic [NREQ*7-1:0] prev_addr;
  logic [NREQ*8-1:0] prev_data;

  always @(negedge clk) begin
    int p;
    logic [NREQ-1:0] oh;
    if (!rst_n) begin
      m_rr = 0; m_act = 1'b0; gnt_clr_due = 1'b0;
      chk("reset_outputs", {gnt, done, err, m_start, m_data}, 0);
    end else begin
      chk("gnt_onehot0", ($countones(gnt) <= 1), 1);
      chk("done_err_excl", (|done) && (|err), 0);
      if (gnt_clr_due) chk("gnt_clear_after_end", gnt, 0);
      gnt_clr_due = 1'b0;
      if (gnt != 0 && prev_gnt == 0) begin
        p  = pick_rr(prev_req, m_rr);
        oh = (p < 0) ? '0 : NREQ'(1) << p;
        chk("grant_choice", gnt, oh);
        m_idx = (p < 0) ? 0 : p;
        m_act = 1'b1; m_bytes = 0;
        m_addr = prev_addr[m_idx*7 +: 7];
        m_dat  = prev_data[m_idx*8 +: 8];
      end
      if (m_start) begin
        chk("start_in_xfer", {m_act, m_bytes < 2}, 2'b11);
        last_byte = (m_bytes == 0) ? {m_addr, 1'b0} : m_dat;
        chk("m_data_at_start", m_data, last_byte);
        m_bytes++;
      end else if (m_act && m_bytes > 0 && err == 0) begin
        chk("m_data_hold", m_data, last_byte);
      end
      oh = NREQ'(1) << m_idx;
      if (done != 0) begin
        chk("done_vec", {m_act, done}, {1'b1, oh});
        chk("done_bytes", m_bytes, 2);
      end
      if (err != 0) begin
        chk("err_vec", {m_act, err}, {1'b1, oh});
        chk("err_mdata_zero", m_data, 0);
      end
      if (done != 0 || err != 0) begin
        m_rr = (m_idx + 1) % NREQ;
        m_act = 1'b0; gnt_clr_due = 1'b1;
      end
    end
    prev_gnt = gnt; prev_req = req; prev_addr = req_addr; prev_data = req_data;
  end

  initial begin
    logic [NREQ-1:0] d, e;
    logic [NREQ-1:0] exp_ord [5];
    logic [7:0]      sdat [2];
    int              c, nstart, ndone, pos_done;
    int              spos [2];
    logic [NREQ-1:0] dval;

    exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; req = '0;
    for (int i = 0; i < NREQ; i++) set_rq(i, 7'h10 + 7'(i), 8'h30 + 8'(i));
    set_rq(0, 7'h50, 8'hA5);
    tick(); tick();
    chk("init_reset_state", {gnt, done, err, m_start, m_data}, 0);
    rst_n = 1'b1;
    tick();

    // T2: all requesting, served 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_pulse("t2_wait", d, e, c);
      chk($sformatf("t2_order_%0d", k), {e, d}, {4'b0000, exp_ord[k]});
      if (k == 1) chk("t2_gap_cycles", c, 12);
      if (k == 4) req = '0;
    end
    tick(); tick();

    // T1: single transfer, cycle-exact
    req = 4'b0001; nstart = 0; ndone = 0; pos_done = -1; dval = '0;
    spos = '{-1, -1}; sdat = '{8'h00, 8'h00};
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 0) chk("t1_gnt_latency", gnt, 4'b0001);
      if (m_start) begin
        if (nstart < 2) begin spos[nstart] = i; sdat[nstart] = m_data; end
        nstart++;
      end
      if (done != 0) begin pos_done = i; dval = done; ndone++; req = '0; end
      if (i == 12) chk("t1_gnt_off", gnt, 0);
    end
    chk("t1_starts", nstart, 2);
    chk("t1_start_pos", {spos[0][7:0], spos[1][7:0]}, {8'd1, 8'd6});
    chk("t1_bytes", {sdat[0], sdat[1]}, {8'hA0, 8'hA5});
    chk("t1_done", {ndone[7:0], pos_done[7:0], 4'(dval)}, {8'd1, 8'd10, 4'b0001});
    tick();

    // T3: serve 1, then 0011 wraps to 0
    req = 4'b0010;
    wait_pulse("t3_first", d, e, c);
    chk("t3_served1", d, 4'b0010);
    req = '0; tick(); tick();
    req = 4'b0011;
    wait_gnt("t3_gnt");
    chk("t3_wrap_grant", gnt, 4'b0001);
    wait_pulse("t3_second", d, e, c);
    chk("t3_done0", d, 4'b0001);
    req = 4'b0010;
    wait_pulse("t3_third", d, e, c);
    chk("t3_done1", d, 4'b0010);
    req = '0; tick(); tick();

    // T4: stuck master, rr=2 -> requester 2 aborts, then 1 is served
    stuck = 1'b1; req = 4'b0110;
    wait_gnt("t4_gnt");
    chk("t4_grant", gnt, 4'b0100);
    c = 0;
    while (!m_start && c < 10) begin tick(); c++; end
    chk("t4_start_seen", m_start, 1);
    wait_pulse("t4_abort", d, e, c);
    chk("t4_err", {d, e}, {4'b0000, 4'b0100});
    chk("t4_err_delay", c, TIMEOUT);
    stuck = 1'b0; req = 4'b0010;
    wait_pulse("t4_next", d, e, c);
    chk("t4_next_done", {d, e}, {4'b0010, 4'b0000});
    req = '0; tick(); tick();

    // T6: data changed and req dropped after grant; latched byte still sent
    req = 4'b0001;
    wait_gnt("t6_gnt");
    req_data[7:0] = 8'h00; req = '0;
    nstart = 0; sdat = '{8'h00, 8'h00}; dval = '0;
    for (int i = 0; i < 30 && dval == 0; i++) begin
      tick();
      if (m_start) begin
        if (nstart < 2) sdat[nstart] = m_data;
        nstart++;
      end
      if (done != 0) dval = done;
    end
    chk("t6_data_byte", sdat[1], 8'hA5);
    chk("t6_done", dval, 4'b0001);
    req_data[7:0] = 8'hA5;
    tick(); tick();

    // T5: reset in WAIT_LO while serving 1; restart grants 0
    req = 4'b0111;
    wait_gnt("t5_gnt");
    chk("t5_grant", gnt, 4'b0010);
    tick(); tick();
    chk("t5_busy_phase", m_busy, 1);
    rst_n = 1'b0; #1;
    chk("t5_async_reset", {gnt, done, err, m_start, m_data}, 0);
    tick(); tick();
    rst_n = 1'b1;
    wait_gnt("t5_regnt");
    chk("t5_restart_0", gnt, 4'b0001);
    req = '0;
    wait_pulse("t5_finish", d, e, c);
    chk("t5_done", d, 4'b0001);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
